tone_mixer: RTL and testbench

TONE_MIXER -- requirements
Module: tone_mixer

---
 rtl/tone_pkg.sv | 32 +++
 rtl/tone_channel.sv | 61 ++++++
 rtl/tone_mixer.sv | 86 ++++++++
 tb/tb_tone_mixer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared state type, default amplitude and saturating arithmetic for the tone mixer.
package tone_pkg;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} ch_state_e;

  localparam logic signed [31:0] DEF_AMPLITUDE = 32'sd10000000;

  // Wide enough for eight full-scale channels; every sum is widened to this before clamping.
  localparam int SAT_W = 36;

  localparam logic signed [31:0] S32_MAX = 32'sh7fff_ffff;
  localparam logic signed [31:0] S32_MIN = 32'sh8000_0000;

  function automatic logic signed [31:0] sat32(input logic signed [SAT_W-1:0] v);
    logic [SAT_W-32:0] top;
    top = v[SAT_W-1:31];
    if (top == '0 || top == '1)
      return v[31:0];
    else if (v[SAT_W-1])
      return S32_MIN;
    else
      return S32_MAX;
  endfunction

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [SAT_W-1:0] s;
    s = SAT_W'(a) + SAT_W'(b);
    return sat32(s);
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone channel: IDLE/PLAY state, half-period counter, phase and
// remaining-sample count. Outputs are registered.
module tone_channel
  import tone_pkg::*;
#(
  parameter int PER_W = 19,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [PER_W-1:0] half_period,
  input  logic [DUR_W-1:0] duration,
  input  logic             wr,
  output logic             busy,
  output logic             phase
);

  ch_state_e        state;
  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] cnt_q;
  logic [DUR_W-1:0] rem_q;
  logic             start;

  assign start = trig && (half_period != '0) && (duration != '0);

  // A valid trigger takes priority over the final write so a retrigger is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      per_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      phase <= 1'b0;
    end else if (start) begin
      state <= PLAY;
      per_q <= half_period;
      rem_q <= duration;
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (state == PLAY) begin
      if (cnt_q == per_q) begin
        cnt_q <= '0;
        phase <= ~phase;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (wr) begin
        rem_q <= rem_q - 1'b1;
        if (rem_q == DUR_W'(1)) begin
          state <= IDLE;
          cnt_q <= '0;
          phase <= 1'b0;
        end
      end
    end
  end

  assign busy = (state == PLAY);

endmodule

// File: rtl/tone_mixer.sv
// Mixes NUM_CH square-wave tone channels into a saturated sample for the audio DAC FIFO.
// Define TONE_MIC_MIX_EN to add the ADC input samples to each output channel.
module tone_mixer
  import tone_pkg::*;
#(
  parameter int                 NUM_CH    = 4,
  parameter int                 PER_W     = 19,
  parameter int                 DUR_W     = 16,
  parameter logic signed [31:0] AMPLITUDE = DEF_AMPLITUDE
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         trig,
  input  logic [NUM_CH*PER_W-1:0]   half_period,
  input  logic [NUM_CH*DUR_W-1:0]   duration,
  output logic [NUM_CH-1:0]         busy,
  input  logic                      audio_out_allowed,
  input  logic                      audio_in_available,
  input  logic signed [31:0]        left_channel_audio_in,
  input  logic signed [31:0]        right_channel_audio_in,
  output logic                      read_audio_in,
  output logic                      write_audio_out,
  output logic signed [31:0]        left_channel_audio_out,
  output logic signed [31:0]        right_channel_audio_out
);

  localparam int MIX_W = 32 + $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0]        phase;
  logic                     wr;
  logic signed [MIX_W-1:0]  sum;
  logic signed [31:0]       mix_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tone_channel #(
      .PER_W (PER_W),
      .DUR_W (DUR_W)
    ) u_ch (
      .clk         (CLOCK_50),
      .reset       (reset),
      .trig        (trig[g]),
      .half_period (half_period[g*PER_W +: PER_W]),
      .duration    (duration[g*DUR_W +: DUR_W]),
      .wr          (wr),
      .busy        (busy[g]),
      .phase       (phase[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (busy[i]) begin
        if (phase[i])
          sum = sum + MIX_W'(AMPLITUDE);
        else
          sum = sum - MIX_W'(AMPLITUDE);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      mix_q <= '0;
    else
      mix_q <= sat32(SAT_W'(sum));
  end

`ifdef TONE_MIC_MIX_EN
  // Pass-through mode moves one ADC sample per DAC sample, so both FIFOs must be ready.
  assign wr                      = audio_in_available & audio_out_allowed & ~reset;
  assign read_audio_in           = wr;
  assign left_channel_audio_out  = reset ? '0 : sat_add(left_channel_audio_in, mix_q);
  assign right_channel_audio_out = reset ? '0 : sat_add(right_channel_audio_in, mix_q);
`else
  logic unused_audio_in;
  assign unused_audio_in         = ^{left_channel_audio_in, right_channel_audio_in};
  assign wr                      = audio_out_allowed & ~reset;
  assign read_audio_in           = audio_in_available & ~reset;
  assign left_channel_audio_out  = reset ? '0 : mix_q;
  assign right_channel_audio_out = reset ? '0 : mix_q;
`endif

  assign write_audio_out = wr;

endmodule

// File: tb/tb_tone_mixer.sv
// Scoreboard bench for tone_mixer: a default-amplitude and a 2^30-amplitude instance share stimulus.
module tb_tone_mixer;

  localparam int NUM_CH = 4;
  localparam int PER_W  = 19;
  localparam int DUR_W  = 16;
  localparam longint A_DEF = 64'sd10000000;
  localparam longint A_BIG = 64'sd1073741824;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  typedef struct {
    logic [NUM_CH-1:0] busy;
    logic [31:0]       l;
    logic [31:0]       r;
    logic [31:0]       lb;
    logic [31:0]       rb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CH-1:0] trig = '0;
  logic [PER_W-1:0] hp [NUM_CH];
  logic [DUR_W-1:0] du [NUM_CH];
  logic [NUM_CH*PER_W-1:0] half_period;
  logic [NUM_CH*DUR_W-1:0] duration;
  logic allowed = 1'b0;
  logic available = 1'b1;
  logic signed [31:0] left_in = '0;
  logic signed [31:0] right_in = '0;

  logic [NUM_CH-1:0] busy, busy_b;
  logic write_audio_out, read_audio_in, write_b, read_b;
  logic signed [31:0] left_out, right_out, left_out_b, right_out_b;

  exp_t sbq[$];
  exp_t e;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      half_period[i*PER_W +: PER_W] = hp[i];
      duration[i*DUR_W +: DUR_W]    = du[i];
    end
  end

  tone_mixer #(.NUM_CH(NUM_CH), .PER_W(PER_W), .DUR_W(DUR_W)) dut (
    .CLOCK_50 (clk), .reset (reset), .trig (trig),
    .half_period (half_period), .duration (duration), .busy (busy),
    .audio_out_allowed (allowed), .audio_in_available (available),
    .left_channel_audio_in (left_in), .right_channel_audio_in (right_in),
    .read_audio_in (read_audio_in), .write_audio_out (write_audio_out),
    .left_channel_audio_out (left_out), .right_channel_audio_out (right_out)
  );

  tone_mixer #(.NUM_CH(NUM_CH), .PER_W(PER_W), .DUR_W(DUR_W),
               .AMPLITUDE(32'sd1073741824)) dut_big (
    .CLOCK_50 (clk), .reset (reset), .trig (trig),
    .half_period (half_period), .duration (duration), .busy (busy_b),
    .audio_out_allowed (allowed), .audio_in_available (available),
    .left_channel_audio_in (left_in), .right_channel_audio_in (right_in),
    .read_audio_in (read_b), .write_audio_out (write_b),
    .left_channel_audio_out (left_out_b), .right_channel_audio_out (right_out_b)
  );

  function automatic longint clamp(input longint v);
    if (v > S_MAX) return S_MAX;
    if (v < S_MIN) return S_MIN;
    return v;
  endfunction

  function automatic logic exp_write(input logic rst, input logic al, input logic av);
`ifdef TONE_MIC_MIX_EN
    return !rst && al && av;
`else
    return !rst && al;
`endif
  endfunction

  function automatic logic exp_read(input logic rst, input logic al, input logic av);
`ifdef TONE_MIC_MIX_EN
    return !rst && al && av;
`else
    return !rst && av;
`endif
  endfunction

  // Expected sample after one clock: units = signed count of channels at +amplitude.
  task automatic push_exp(input logic [NUM_CH-1:0] b, input int u,
                          input longint li = 0, input longint ri = 0);
    exp_t x;
    longint m, mb;
    m  = clamp(longint'(u) * A_DEF);
    mb = clamp(longint'(u) * A_BIG);
    x.busy = b;
`ifdef TONE_MIC_MIX_EN
    x.l  = 32'(clamp(li + m));
    x.r  = 32'(clamp(ri + m));
    x.lb = 32'(clamp(li + mb));
    x.rb = 32'(clamp(ri + mb));
`else
    x.l  = 32'(m);
    x.r  = 32'(m);
    x.lb = 32'(mb);
    x.rb = 32'(mb);
`endif
    sbq.push_back(x);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) push_exp('0, 0);
    trig = '1; allowed = 1'b1; available = 1'b1; reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if ({write_audio_out, read_audio_in, write_b, read_b} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_handshake k=%0d wr=%b rd=%b want 0 0", k, write_audio_out, read_audio_in);
      end
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if ({busy, left_out, right_out, busy_b, left_out_b, right_out_b} !== {e.busy, e.l, e.r, e.busy, e.lb, e.rb}) begin
        n_err++;
        $display("FAIL reset_state k=%0d busy=%b out=%0d,%0d big=%0d want busy=%b out=%0d,%0d big=%0d",
                 k, busy, left_out, right_out, left_out_b, e.busy, $signed(e.l), $signed(e.r), $signed(e.lb));
      end
    end
    reset = 1'b0; trig = '0; allowed = 1'b0;
  endtask

  task automatic test_tone();
    hp[0] = 3; du[0] = 4;
    for (int k = 0; k < 11; k++) begin
      int kk = k + 1;
      push_exp((kk <= 7) ? 4'b0001 : 4'b0000,
               (kk >= 2 && kk <= 5) ? 1 : (kk >= 6 && kk <= 8) ? -1 : 0);
    end
    for (int k = 0; k < 11; k++) begin
      trig = (k == 0) ? 4'b0001 : 4'b0000;
      allowed = (k % 2 == 1);
      #1;
      n_vec++;
      if (write_audio_out !== exp_write(reset, allowed, available) || read_audio_in !== exp_read(reset, allowed, available)) begin
        n_err++;
        $display("FAIL tone_handshake k=%0d wr=%b rd=%b want %b %b", k, write_audio_out, read_audio_in,
                 exp_write(reset, allowed, available), exp_read(reset, allowed, available));
      end
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if ({busy, left_out, right_out, busy_b, left_out_b, right_out_b} !== {e.busy, e.l, e.r, e.busy, e.lb, e.rb}) begin
        n_err++;
        $display("FAIL tone k=%0d busy=%b out=%0d,%0d big=%0d want busy=%b out=%0d,%0d big=%0d",
                 k, busy, left_out, right_out, left_out_b, e.busy, $signed(e.l), $signed(e.r), $signed(e.lb));
      end
    end
    trig = '0; allowed = 1'b0;
  endtask

  task automatic test_invalid();
    for (int k = 0; k < 6; k++) push_exp('0, 0);
    for (int k = 0; k < 6; k++) begin
      hp[2] = (k == 0) ? 0 : 5;
      du[2] = (k == 0) ? 5 : 0;
      trig = (k == 0 || k == 2) ? 4'b0100 : 4'b0000;
      allowed = 1'b1;
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if ({busy, left_out, right_out, busy_b, left_out_b} !== {e.busy, e.l, e.r, e.busy, e.lb}) begin
        n_err++;
        $display("FAIL invalid_trig k=%0d busy=%b out=%0d,%0d want busy=%b out=%0d",
                 k, busy, left_out, right_out, e.busy, $signed(e.l));
      end
    end
    trig = '0; allowed = 1'b0;
  endtask

  // Part 0: retrigger at remaining=2 with duration 5. Part 1: retrigger on the final write.
  task automatic test_retrigger();
    logic [8:0] trig_tab [2];
    logic [8:0] al_tab [2];
    int n_it [2];
    trig_tab[0] = 9'b000000101; al_tab[0] = 9'b111111110; n_it[0] = 9;
    trig_tab[1] = 9'b000000101; al_tab[1] = 9'b000011110; n_it[1] = 6;
    for (int kk = 1; kk <= 9; kk++)
      push_exp((kk <= 7) ? 4'b0010 : 4'b0000,
               (kk >= 2 && kk <= 6) ? 1 : (kk >= 7 && kk <= 8) ? -1 : 0);
    for (int kk = 1; kk <= 6; kk++)
      push_exp((kk <= 4) ? 4'b0010 : 4'b0000, (kk >= 2 && kk <= 5) ? 1 : 0);
    hp[1] = 2;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < n_it[p]; k++) begin
        du[1] = (p == 1) ? 2 : (k == 0) ? 3 : 5;
        trig = trig_tab[p][k] ? 4'b0010 : 4'b0000;
        allowed = al_tab[p][k];
        @(posedge clk); #1;
        e = sbq.pop_front();
        n_vec++;
        if ({busy, left_out, right_out, busy_b, left_out_b} !== {e.busy, e.l, e.r, e.busy, e.lb}) begin
          n_err++;
          $display("FAIL retrigger part=%0d k=%0d busy=%b out=%0d,%0d want busy=%b out=%0d",
                   p, k, busy, left_out, right_out, e.busy, $signed(e.l));
        end
      end
    end
    trig = '0; allowed = 1'b0;
  endtask

  // Leaves all four channels playing for the mid-tone reset test.
  task automatic test_saturation();
    for (int i = 0; i < NUM_CH; i++) begin hp[i] = 3; du[i] = 8; end
    for (int kk = 1; kk <= 9; kk++)
      push_exp(4'b1111, (kk >= 2 && kk <= 5) ? 4 : (kk >= 6) ? -4 : 0);
    for (int k = 0; k < 9; k++) begin
      trig = (k == 0) ? 4'b1111 : 4'b0000;
      allowed = 1'b0;
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if ({busy, left_out, right_out, busy_b, left_out_b, right_out_b} !== {e.busy, e.l, e.r, e.busy, e.lb, e.rb}) begin
        n_err++;
        $display("FAIL saturation k=%0d out=%0d big=%0d,%0d want out=%0d big=%0d,%0d",
                 k, left_out, left_out_b, right_out_b, $signed(e.l), $signed(e.lb), $signed(e.rb));
      end
    end
    trig = '0;
  endtask

  task automatic test_reset_mid_tone();
    push_exp('0, 0);
    push_exp('0, 0);
    for (int k = 0; k < 2; k++) begin
      reset = (k == 0);
      allowed = 1'b1;
      #1;
      n_vec++;
      if (write_audio_out !== exp_write(reset, allowed, available) || read_audio_in !== exp_read(reset, allowed, available)) begin
        n_err++;
        $display("FAIL reset_mid_handshake k=%0d wr=%b rd=%b want %b %b", k, write_audio_out, read_audio_in,
                 exp_write(reset, allowed, available), exp_read(reset, allowed, available));
      end
      allowed = (k == 0);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if ({busy, left_out, right_out, busy_b, left_out_b} !== {e.busy, e.l, e.r, e.busy, e.lb}) begin
        n_err++;
        $display("FAIL reset_mid k=%0d busy=%b out=%0d,%0d want busy=%b out=%0d",
                 k, busy, left_out, right_out, e.busy, $signed(e.l));
      end
    end
    reset = 1'b0; allowed = 1'b0;
  endtask

  task automatic test_mic_mix();
    left_in = 32'sd100;
    right_in = 32'sh8000_0000;
    hp[0] = 100; du[0] = 1;
    push_exp(4'b0001, 0, 100, S_MIN);
    push_exp(4'b0001, 1, 100, S_MIN);
    push_exp(4'b0000, 1, 100, S_MIN);
    push_exp(4'b0000, 0, 100, S_MIN);
    for (int k = 0; k < 4; k++) begin
      trig = (k == 0) ? 4'b0001 : 4'b0000;
      allowed = (k == 2);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_vec++;
      if ({busy, left_out, right_out, left_out_b, right_out_b} !== {e.busy, e.l, e.r, e.lb, e.rb}) begin
        n_err++;
        $display("FAIL mic_mix k=%0d busy=%b out=%0d,%0d big=%0d,%0d want busy=%b out=%0d,%0d big=%0d,%0d",
                 k, busy, left_out, right_out, left_out_b, right_out_b,
                 e.busy, $signed(e.l), $signed(e.r), $signed(e.lb), $signed(e.rb));
      end
    end
    left_in = '0; right_in = '0; trig = '0; allowed = 1'b0;
  endtask

  task automatic test_handshake();
    for (int k = 0; k < 24; k++) begin
      allowed = 1'($urandom_range(0, 1));
      available = 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if ({write_audio_out, read_audio_in} !== {exp_write(reset, allowed, available), exp_read(reset, allowed, available)}) begin
        n_err++;
        $display("FAIL handshake k=%0d al=%b av=%b wr=%b rd=%b want %b %b", k, allowed, available,
                 write_audio_out, read_audio_in, exp_write(reset, allowed, available), exp_read(reset, allowed, available));
      end
      @(posedge clk); #1;
    end
    allowed = 1'b0; available = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin hp[i] = 3; du[i] = 4; end
    test_reset();
    test_tone();
    test_invalid();
    test_retrigger();
    test_saturation();
    test_reset_mid_tone();
    test_mic_mix();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
